sram_like_slave: RTL and testbench



---
 rtl/sram_like_slave.sv | 133 +++++++++++++
 tb/tb_sram_like_slave.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sram_like_slave.sv
// Responder for the sram-like req/addr_ok/data_ok bus, backed by a word-addressed memory.
// Define SRAM_SLV_RAND_STALL_EN to add LFSR-driven pseudo-random address-phase stalls.
module sram_like_slave #(
   parameter int MEM_AW          = 12,
   parameter int LATENCY         = 2,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              wr,
   input  logic [1:0]        size,
   input  logic [3:0]        wstrb,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic              addr_ok,
   output logic              data_ok,
   output logic [31:0]       rdata,
   input  logic              init_we,
   input  logic [MEM_AW-1:0] init_addr,
   input  logic [31:0]       init_data
);
   localparam int CW = 4;

   typedef struct packed {
      logic        wr;
      logic [31:0] data;
   } ent_t;

   logic [31:0]       mem [0:(1<<MEM_AW)-1];
   logic [MEM_AW-1:0] widx;
   logic [CW-1:0]     count;
   logic              hs;
   logic              slot_free;
   ent_t              hs_ent;
   ent_t              last_in;
   logic              last_vld_in;
   logic              dok_q;
   logic [31:0]       rdata_q;
   logic              unused_ok;

   assign widx      = addr[MEM_AW+1:2];
   assign unused_ok = ^{size, addr[31:MEM_AW+2], addr[1:0]};
   assign slot_free = (count < CW'(MAX_OUTSTANDING)) || data_ok;

`ifdef SRAM_SLV_RAND_STALL_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk) begin
      if (reset) lfsr <= 16'hACE1;
      else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   assign addr_ok = req && slot_free && (lfsr[1:0] != 2'b00);
`else
   assign addr_ok = req && slot_free;
`endif

   assign hs = addr_ok && !reset;

   // Read data is taken from the array before this edge's writes land, so a read
   // never sees a same-edge backdoor write.
   always_comb begin
      hs_ent      = '0;
      hs_ent.wr   = wr;
      hs_ent.data = mem[widx];
   end

   // Backdoor first, bus second: the bus write wins on its strobed lanes.
   always_ff @(posedge clk) begin
      if (init_we) mem[init_addr] <= init_data;
      if (hs && wr) begin
         for (int b = 0; b < 4; b++)
            if (wstrb[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

   generate
      if (LATENCY == 1) begin : g_direct
         assign last_in     = hs_ent;
         assign last_vld_in = hs;
      end else begin : g_pipe
         logic [LATENCY-1:1] vld_pipe;
         ent_t [LATENCY-1:1] ent_pipe;

         always_ff @(posedge clk) begin
            if (reset) begin
               vld_pipe <= '0;
               ent_pipe <= '0;
            end else begin
               for (int i = LATENCY-1; i >= 2; i--) begin
                  vld_pipe[i] <= vld_pipe[i-1];
                  ent_pipe[i] <= ent_pipe[i-1];
               end
               vld_pipe[1] <= hs;
               ent_pipe[1] <= hs_ent;
            end
         end

         assign last_in     = ent_pipe[LATENCY-1];
         assign last_vld_in = vld_pipe[LATENCY-1];
      end
   endgenerate

   // Final stage: rdata only moves on read responses, writes leave it untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         dok_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         dok_q <= last_vld_in;
         if (last_vld_in && !last_in.wr) rdata_q <= last_in.data;
      end
   end

   assign data_ok = dok_q;
   assign rdata   = rdata_q;

   always_ff @(posedge clk) begin
      if (reset) count <= '0;
      else begin
         case ({hs, data_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assert property (@(posedge clk) disable iff (reset) data_ok |-> (count != '0));
   assert property (@(posedge clk) disable iff (reset) count <= CW'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_sram_like_slave.sv
// Randomized bench for sram_like_slave against a queue-based transaction model.
module tb_sram_like_slave;
   localparam int LAT1 = 2, MAX1 = 4;
   localparam int LAT2 = 4, MAX2 = 2;

   logic        clk = 0, reset = 1;
   logic        req = 0, wr = 0, req2 = 0;
   logic [1:0]  size = 0;
   logic [3:0]  wstrb = 0;
   logic [31:0] addr = 0, wdata = 0;
   logic        init_we = 0;
   logic [11:0] init_addr = 0;
   logic [31:0] init_data = 0;
   logic        addr_ok, data_ok, b_addr_ok, b_data_ok;
   logic [31:0] rdata, b_rdata;

   always #5 clk = ~clk;

   sram_like_slave #(.MEM_AW(12), .LATENCY(LAT1), .MAX_OUTSTANDING(MAX1)) dut (
      .clk(clk), .reset(reset), .req(req), .wr(wr), .size(size), .wstrb(wstrb),
      .addr(addr), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
      .init_we(init_we), .init_addr(init_addr), .init_data(init_data));

   // Read-only second instance exercising back-pressure at MAX_OUTSTANDING=2, LATENCY=4.
   sram_like_slave #(.MEM_AW(12), .LATENCY(LAT2), .MAX_OUTSTANDING(MAX2)) dut2 (
      .clk(clk), .reset(reset), .req(req2), .wr(1'b0), .size(size), .wstrb(wstrb),
      .addr(addr), .wdata(wdata), .addr_ok(b_addr_ok), .data_ok(b_data_ok), .rdata(b_rdata),
      .init_we(init_we), .init_addr(init_addr), .init_data(init_data));

   typedef struct {
      int          due;
      bit          rd;
      logic [31:0] data;
   } ent_t;

   ent_t        q1[$], q2[$];
   logic [31:0] mm1 [0:4095];
   logic [31:0] mm2 [0:4095];
   logic [31:0] rd_exp1 = 0, rd_exp2 = 0;
   int          cyc = 0;
   int          checks = 0, failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
   task automatic tick();
      bit   dok1, dok2, aok1, aok2, hs1, hs2;
      ent_t e;
      @(negedge clk);
      dok1 = (q1.size() > 0) && (q1[0].due == cyc);
      dok2 = (q2.size() > 0) && (q2[0].due == cyc);
      if (dok1 && q1[0].rd) rd_exp1 = q1[0].data;
      if (dok2) rd_exp2 = q2[0].data;
      aok1 = req  && (q1.size() < MAX1 || dok1);
      aok2 = req2 && (q2.size() < MAX2 || dok2);
      chk("addr_ok",   addr_ok,   aok1);
      chk("data_ok",   data_ok,   dok1);
      chk("rdata",     rdata,     rd_exp1);
      chk("b_addr_ok", b_addr_ok, aok2);
      chk("b_data_ok", b_data_ok, dok2);
      chk("b_rdata",   b_rdata,   rd_exp2);
      hs1 = aok1 && !reset;
      hs2 = aok2 && !reset;
      @(posedge clk);
      cyc++;
      if (reset) begin
         q1.delete(); q2.delete();
         rd_exp1 = 0; rd_exp2 = 0;
      end else begin
         if (dok1) void'(q1.pop_front());
         if (dok2) void'(q2.pop_front());
         if (hs1) begin
            e.due = cyc + LAT1 - 1; e.rd = !wr; e.data = mm1[addr[13:2]];
            q1.push_back(e);
         end
         if (hs2) begin
            e.due = cyc + LAT2 - 1; e.rd = 1; e.data = mm2[addr[13:2]];
            q2.push_back(e);
         end
      end
      if (init_we) begin
         mm1[init_addr] = init_data;
         mm2[init_addr] = init_data;
      end
      if (hs1 && wr)
         for (int b = 0; b < 4; b++)
            if (wstrb[b]) mm1[addr[13:2]][8*b +: 8] = wdata[8*b +: 8];
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      logic [31:0] a;
      idle(2);
      reset = 0;
      tick();
      chk("rst_addr_ok", addr_ok, 0);
      chk("rst_data_ok", data_ok, 0);
      chk("rst_rdata",   rdata,   0);

      // Preload words 0..15 (only these are ever read).
      init_we = 1;
      for (int i = 0; i < 16; i++) begin
         init_addr = 12'(i);
         init_data = (i == 5) ? 32'hDEADBEEF : $urandom;
         tick();
      end
      init_we = 0;

      // Plain read of word 5.
      req = 1; wr = 0; addr = 32'h14;
      tick();
      req = 0;
      idle(3);
      chk("t1_rdata", rdata, 32'hDEADBEEF);

      // Partial write, then read back the merged word.
      req = 1; wr = 1; addr = 32'h14; wstrb = 4'b0011; wdata = 32'h00001234;
      tick();
      wr = 0;
      tick();
      req = 0;
      idle(3);
      chk("t2_rdata", rdata, 32'hDEAD1234);

      // Back-to-back reads of words 0..3.
      req = 1; wr = 0;
      for (int i = 0; i < 4; i++) begin
         addr = 32'(i * 4);
         tick();
      end
      req = 0;
      idle(3);

      // Back-pressure on the second instance with req held high.
      req2 = 1; addr = 32'h8;
      idle(10);
      req2 = 0;
      idle(5);

      // Reset with reads in flight on both instances.
      req = 1; req2 = 1; addr = 32'h0;
      tick();
      addr = 32'h4;
      tick();
      req = 0; req2 = 0;
      reset = 1;
      tick();
      reset = 0;
      idle(6);
      req = 1; addr = 32'h14;
      tick();
      req = 0;
      idle(3);
      chk("t5_mem_kept", rdata, 32'hDEAD1234);

      // Aliased bus write colliding with a backdoor write to word 5.
      req = 1; wr = 1; addr = 32'h00004014; wstrb = 4'hF; wdata = 32'hCAFEF00D;
      init_we = 1; init_addr = 12'd5; init_data = 32'h12345678;
      tick();
      init_we = 0; wr = 0; addr = 32'h14;
      tick();
      req = 0;
      idle(3);
      chk("t6_alias", rdata, 32'hCAFEF00D);

      // Random traffic on both instances, including wstrb=0 writes and backdoor writes.
      for (int i = 0; i < 500; i++) begin
         a = $urandom;
         a[13:2] = 12'($urandom_range(0, 15));
         addr  = a;
         req   = ($urandom_range(0, 9) < 7);
         req2  = ($urandom_range(0, 9) < 6);
         wr    = $urandom_range(0, 1);
         wstrb = 4'($urandom);
         wdata = $urandom;
         size  = 2'($urandom);
         init_we   = ($urandom_range(0, 9) == 0);
         init_addr = 12'($urandom_range(0, 15));
         init_data = $urandom;
         tick();
      end
      req = 0; req2 = 0; init_we = 0;
      idle(8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
